// File: rtl/reg_file_mp_pkg.sv
// Shared constants and FSM encoding for the multi-port register file.
// Optional dump port is enabled with REG_FILE_DUMP_EN.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_N_READ = 2;
  localparam int ZERO_ADDR  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between decode/writeback (master) and the register file (slave).
// Dump signals exist only when REG_FILE_DUMP_EN is defined.
interface reg_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_READ = DEF_N_READ
);

  logic [N_READ*ADDR_W-1:0] AR;
  logic [N_READ*DATA_W-1:0] DR;
  logic [N_READ-1:0]        PEND;
  logic                     REG_WRITE;
  logic [ADDR_W-1:0]        AW;
  logic [DATA_W-1:0]        DIN;
  logic                     RESERVE;
  logic [ADDR_W-1:0]        ARES;
`ifdef REG_FILE_DUMP_EN
  logic                     DUMP_REQ;
  logic                     DUMP_READY;
  logic                     DUMP_VALID;
  logic [ADDR_W-1:0]        DUMP_ADDR;
  logic [DATA_W-1:0]        DUMP_DATA;
  logic                     DUMP_DONE;
`endif

  modport master (
    output AR, REG_WRITE, AW, DIN, RESERVE, ARES,
    input  DR, PEND
`ifdef REG_FILE_DUMP_EN
    , output DUMP_REQ, DUMP_READY,
    input  DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_DONE
`endif
  );

  modport slave (
    input  AR, REG_WRITE, AW, DIN, RESERVE, ARES,
    output DR, PEND
`ifdef REG_FILE_DUMP_EN
    , input DUMP_REQ, DUMP_READY,
    output DUMP_VALID, DUMP_ADDR, DUMP_DATA, DUMP_DONE
`endif
  );

endinterface

// File: rtl/reg_file_mp_dump.sv
// Serial dump FSM: walks every register index and streams its stored value.
// Present only when REG_FILE_DUMP_EN is defined.
`ifdef REG_FILE_DUMP_EN
module reg_file_dump
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              dump_req,
  input  logic              dump_ready,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done,
  output logic [ADDR_W-1:0] rd_idx,
  input  logic [DATA_W-1:0] rd_data
);

  dump_state_e       state, state_nxt;
  logic [ADDR_W-1:0] idx, idx_nxt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (dump_req) begin
          state_nxt = SEND;
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (dump_ready) begin
          idx_nxt = idx + 1'b1;
          if (idx == '1) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs depend on state and index only, so DUMP_READY never reaches them combinationally.
  always_comb begin
    dump_valid = 1'b0;
    dump_addr  = '0;
    dump_data  = '0;
    dump_done  = 1'b0;
    case (state)
      SEND: begin
        dump_valid = 1'b1;
        dump_addr  = idx;
        dump_data  = rd_data;
      end
      DONE:    dump_done = 1'b1;
      default: ;
    endcase
  end

  assign rd_idx = idx;

endmodule
`endif

// File: rtl/reg_file_mp.sv
// Multi-port register file with write bypass, zero register and pending scoreboard.
// Define REG_FILE_DUMP_EN to add the serial dump port (reg_file_dump).
module reg_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_READ = DEF_N_READ
) (
  input  logic          CLK,
  input  logic          RST_N,
  reg_file_mp_if.slave  rf
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0]        mem [DEPTH];
  logic [DEPTH-1:0]         pend;
  logic [ADDR_W-1:0]        rd_addr [N_READ];
  logic                     rd_byp  [N_READ];
  logic [N_READ*DATA_W-1:0] dr_all;
  logic [N_READ-1:0]        pend_all;

  // When reserve and write hit the same register, the later reserve assignment wins.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      pend <= '0;
    end else begin
      if (rf.REG_WRITE && rf.AW != ZERO) mem[rf.AW] <= rf.DIN;
      if (rf.REG_WRITE) pend[rf.AW] <= 1'b0;
      if (rf.RESERVE) pend[rf.ARES] <= 1'b1;
      pend[ZERO_ADDR] <= 1'b0;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    assign rd_addr[k] = rf.AR[k*ADDR_W +: ADDR_W];
    assign rd_byp[k]  = rf.REG_WRITE && (rf.AW == rd_addr[k]);
  end

  always_comb begin
    dr_all   = '0;
    pend_all = '0;
    for (int k = 0; k < N_READ; k++) begin
      if (rd_addr[k] != ZERO) begin
        if (rd_byp[k]) dr_all[k*DATA_W +: DATA_W] = rf.DIN;
        else           dr_all[k*DATA_W +: DATA_W] = mem[rd_addr[k]];
      end
      pend_all[k] = pend[rd_addr[k]] & ~rd_byp[k];
    end
  end

  assign rf.DR   = dr_all;
  assign rf.PEND = pend_all;

`ifdef REG_FILE_DUMP_EN
  logic [ADDR_W-1:0] dump_idx;
  logic [DATA_W-1:0] dump_rd_data;

  assign dump_rd_data = mem[dump_idx];

  reg_file_dump #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_dump (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .dump_req   (rf.DUMP_REQ),
    .dump_ready (rf.DUMP_READY),
    .dump_valid (rf.DUMP_VALID),
    .dump_addr  (rf.DUMP_ADDR),
    .dump_data  (rf.DUMP_DATA),
    .dump_done  (rf.DUMP_DONE),
    .rd_idx     (dump_idx),
    .rd_data    (dump_rd_data)
  );
`endif

endmodule
